// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one result bit per clock, LSB first.
// Cin=0 adds, Cin=1 subtracts (A + ~B + 1). Ca is carry out / not-borrow.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN adds the registered Ovf output
// (two's-complement overflow). Without it the port and its logic are absent.
// Handshake: start is sampled only in IDLE or DONE; an accepted start loads the
// operands, busy is high for the WIDTH shift cycles, then done pulses for one
// cycle while S/Ca (and Ovf) carry the new result and hold it until the next done.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Ca
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_next;

    // Full-adder slice on the current LSBs, plus handshake decode.
    always_comb begin
        sum_bit    = a_sr[0] ^ b_sr[0] ^ c;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
        accept     = start && (state == ST_IDLE || state == ST_DONE);
        last_bit   = (cnt == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start during SHIFT is deliberately ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operand load, bit-serial datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Ca   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            Ovf  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr <= Ain;
            b_sr <= Cin ? ~B : B;
            c    <= Cin;
            cnt  <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr <= {sum_bit, r_sr[WIDTH-1:1]};
            c    <= carry_next;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
                S   <= {sum_bit, r_sr[WIDTH-1:1]};
                Ca  <= carry_next;
`ifdef SERIAL_ADD_SUB_OVF_EN
                // c here is the carry into the MSB slice.
                Ovf <= c ^ carry_next;
`endif
            end
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: self-checking bench for serial_add_sub.
// Define SERIAL_ADD_SUB_OVF_EN to also check the Ovf output.
module tb_serial_add_sub;

    localparam int WIDTH = 4;
    localparam int W     = WIDTH + 2;   // {ovf, ca, s}

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Ca;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             Ovf;
`endif

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ain   (Ain),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Ca    (Ca)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    logic [WIDTH-1:0] last_s;
    int               n_cmp;
    int               n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] model(input int a, input int b, input bit cin);
        int mod;
        int full;
        int sa;
        int sb;
        int sr;
        logic [WIDTH-1:0] s;
        logic ca;
        logic ovf;
        mod  = 1 << WIDTH;
        full = cin ? (a + (mod - 1 - b) + 1) : (a + b);
        s    = WIDTH'(full % mod);
        ca   = (full >= mod);
        sa   = (a >= mod / 2) ? a - mod : a;
        sb   = (b >= mod / 2) ? b - mod : b;
        sr   = cin ? sa - sb : sa + sb;
        ovf  = (sr > mod / 2 - 1) || (sr < -(mod / 2));
        return {ovf, ca, s};
    endfunction

    // ---------------- driver tasks ----------------
    // Drive an operation request at a negedge; the following posedge accepts it.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        Ain   = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        exp_q.push_back(model(int'(a), int'(b), cin));
    endtask

    // Called at the negedge where start was driven. Waits for done, checks
    // latency, result stability while busy, and the result itself.
    task automatic finish_op(input string tag, input bit inject);
        int n;
        logic [W-1:0] e;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        while (!done && n <= WIDTH + 4) begin
            check({tag, "_s_hold"}, 32'(S), 32'(last_s));
            if (inject && n == 2) begin
                start = 1'b1;
                Ain   = WIDTH'($urandom);
                B     = WIDTH'($urandom);
                Cin   = 1'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!done && n <= WIDTH) check({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_S"}, 32'(S), 32'(e[WIDTH-1:0]));
            check({tag, "_Ca"}, 32'(Ca), 32'(e[WIDTH]));
`ifdef SERIAL_ADD_SUB_OVF_EN
            check({tag, "_Ovf"}, 32'(Ovf), 32'(e[WIDTH+1]));
`endif
            last_s = e[WIDTH-1:0];
        end else begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end
    endtask

    // One step after done with no new start: pulse must have ended.
    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_S_held"}, 32'(S), 32'(last_s));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        last_s = '0;
        rst    = 1'b1;
        start  = 1'b0;
        Ain    = '0;
        B      = '0;
        Cin    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_Ca", 32'(Ca), 32'd0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("rst_Ovf", 32'(Ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed operations.
        start_op(4'b1100, 4'b0111, 1'b1); finish_op("sub1", 1'b0); check_idle_after("sub1");
        start_op(4'b0101, 4'b1001, 1'b1); finish_op("sub2", 1'b0); check_idle_after("sub2");
        start_op(4'b0111, 4'b0101, 1'b0); finish_op("add3", 1'b0); check_idle_after("add3");
        start_op(4'b1001, 4'b1000, 1'b0); finish_op("add4", 1'b0); check_idle_after("add4");
        start_op(4'b1010, 4'b0000, 1'b1); finish_op("subzero", 1'b0); check_idle_after("subzero");
        start_op(4'b1111, 4'b0001, 1'b0); finish_op("addwrap", 1'b0); check_idle_after("addwrap");

        // start mid-SHIFT is ignored: single done, then idle.
        start_op(4'b0011, 4'b0110, 1'b1); finish_op("midstart", 1'b1); check_idle_after("midstart");

        // start held in DONE: back-to-back ops, one done pulse each.
        start_op(4'b0110, 4'b0011, 1'b0); finish_op("b2b_a", 1'b0);
        start_op(4'b0010, 4'b1101, 1'b1); finish_op("b2b_b", 1'b0);
        start_op(4'b1000, 4'b1000, 1'b1); finish_op("b2b_c", 1'b0); check_idle_after("b2b_c");

        // Asynchronous reset in the middle of SHIFT aborts the operation.
        start_op(4'b1011, 4'b0100, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_S", 32'(S), 32'd0);
        check("async_rst_Ca", 32'(Ca), 32'd0);
        void'(exp_q.pop_back());
        last_s = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
        end
        start_op(4'b1101, 4'b0110, 1'b1); finish_op("post_rst", 1'b0); check_idle_after("post_rst");

        // Randomized operations, some chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            finish_op("rand", 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) != 0) check_idle_after("rand");
        end
        check_idle_after("final");
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
